// File: rtl/seg7_capture.sv
// seg7_capture: debounces a 7-segment bus, decodes stable patterns to hex
// digits and queues new digits in a FIFO with a valid/ready output.
// Ports: clk, rst_n (async, active low), sample_en, seg_in[6:0] (a..g),
//        digit_data[3:0], digit_valid, digit_ready, locked,
//        bad_count[7:0], overflow.
// Macro SEG7_ACTIVE_LOW_EN: invert seg_in for common-anode displays.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_data,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       locked,
  output logic [7:0] bad_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t r_state, w_state_nx;
  logic [6:0] r_held, w_held_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic [6:0] w_seg;
  logic [3:0] w_dig;
  logic w_blank, w_legal, w_bad, w_accept;
  logic [3:0] r_last;
  logic r_last_vld;
  logic [7:0] r_bad;
  logic r_ovf;
  logic w_push;

  logic [3:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_rd_nx;
  logic [AW:0] r_count, w_count_nx;
  logic [3:0] r_data, w_head;
  logic w_pop, w_full, w_wr, w_drop;

`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg = ~seg_in;
`else
  assign w_seg = seg_in;
`endif

  always_comb begin
    w_dig   = 4'h0;
    w_blank = 1'b0;
    w_legal = 1'b1;
    case (w_seg)
      7'h3F: w_dig = 4'h0;
      7'h06: w_dig = 4'h1;
      7'h5B: w_dig = 4'h2;
      7'h4F: w_dig = 4'h3;
      7'h66: w_dig = 4'h4;
      7'h6D: w_dig = 4'h5;
      7'h7D: w_dig = 4'h6;
      7'h07: w_dig = 4'h7;
      7'h7F: w_dig = 4'h8;
      7'h6F: w_dig = 4'h9;
      7'h77: w_dig = 4'hA;
      7'h7C: w_dig = 4'hB;
      7'h39: w_dig = 4'hC;
      7'h5E: w_dig = 4'hD;
      7'h79: w_dig = 4'hE;
      7'h71: w_dig = 4'hF;
      7'h00: begin
        w_blank = 1'b1;
        w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_bad = !w_legal && !w_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_held  <= 7'h00;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_held  <= w_held_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Acceptance always evaluates the live pattern, which equals the
  // (new) held pattern whenever w_accept is asserted.
  always_comb begin
    w_state_nx = r_state;
    w_held_nx  = r_held;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    if (sample_en) begin
      if (w_seg != r_held) begin
        w_held_nx = w_seg;
        w_cnt_nx  = 8'd1;
        if (SC == 8'd1) begin
          w_accept   = 1'b1;
          w_state_nx = LOCKED;
        end else begin
          w_state_nx = SETTLE;
        end
      end else begin
        unique case (r_state)
          SETTLE: begin
            w_cnt_nx = r_cnt + 8'd1;
            if (w_cnt_nx == SC) begin
              w_accept   = 1'b1;
              w_state_nx = LOCKED;
            end
          end
          IDLE, LOCKED: w_state_nx = r_state;
          default: w_state_nx = IDLE;
        endcase
      end
    end
  end

  assign locked = (r_state == LOCKED);
  assign w_push = w_accept && w_legal &&
                  (!r_last_vld || r_last != w_dig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 4'h0;
      r_last_vld <= 1'b0;
      r_bad      <= 8'h00;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept && w_blank)
        r_last_vld <= 1'b0;
      if (w_push) begin
        r_last     <= w_dig;
        r_last_vld <= 1'b1;
      end
      if (w_accept && w_bad && r_bad != 8'hFF)
        r_bad <= r_bad + 8'd1;
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign w_pop  = digit_valid && digit_ready;
  assign w_full = (r_count == FULL);
  // A simultaneous pop frees the slot the push needs.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;
  assign w_rd_nx = r_rd + AW'(w_pop);
  assign w_count_nx = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  // Pushed digit becomes the head when it lands on the next read slot.
  assign w_head = (w_wr && w_rd_nx == r_wr) ? w_dig : r_mem[w_rd_nx];

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr] <= w_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_data  <= 4'h0;
    end else begin
      r_rd    <= w_rd_nx;
      r_count <= w_count_nx;
      if (w_wr)
        r_wr <= r_wr + AW'(1);
      if (w_count_nx != '0)
        r_data <= w_head;
    end
  end

  assign digit_data  = r_data;
  assign digit_valid = (r_count != '0);
  assign bad_count   = r_bad;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed bench for seg7_capture.
// Collects popped digits at negedge and compares against fixed vectors.
module tb_seg7_capture;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic [6:0] seg_in;
  logic [3:0] digit_data;
  logic       digit_valid;
  logic       digit_ready;
  logic       locked;
  logic [7:0] bad_count;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] got_q[$];

  seg7_capture #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .seg_in(seg_in),
    .digit_data(digit_data),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .locked(locked),
    .bad_count(bad_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && digit_valid && digit_ready)
      got_q.push_back(digit_data);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pin(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic logic [31:0] q_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    return 32'hDEAD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = pin(p);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    seg_in = pin(7'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    got_q.delete();
  endtask

  logic saw_lock;

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b1;
    digit_ready = 1'b0;
    seg_in = pin(7'h3F);
    repeat (2) tick();
    chk("rst_valid", digit_valid, 0);
    chk("rst_data", digit_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_bad", bad_count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_early", digit_valid, 0);
    tick();
    chk("t1_valid", digit_valid, 1);
    chk("t1_data", digit_data, 0);
    chk("t1_locked", locked, 1);
    repeat (6) tick();
    digit_ready = 1'b1;
    tick();
    digit_ready = 1'b0;
    chk("t1_empty", digit_valid, 0);
    chk("t1_n", got_q.size(), 1);
    chk("t1_d0", q_at(0), 0);

    do_reset();
    digit_ready = 1'b1;
    saw_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seg_in = pin(i[0] ? 7'h5B : 7'h06);
      repeat (2) begin
        tick();
        saw_lock |= locked;
      end
    end
    chk("t2_lock", saw_lock, 0);
    chk("t2_n", got_q.size(), 0);
    chk("t2_bad", bad_count, 0);

    do_reset();
    digit_ready = 1'b1;
    hold(7'h4F, 6);
    chk("t3_first", got_q.size(), 1);
    hold(7'h00, 6);
    hold(7'h4F, 12);
    hold(7'h00, 2);
    chk("t3_n", got_q.size(), 2);
    chk("t3_d0", q_at(0), 3);
    chk("t3_d1", q_at(1), 3);

    do_reset();
    digit_ready = 1'b1;
    hold(7'h12, 8);
    chk("t4_bad_locked", locked, 1);
    hold(7'h7F, 8);
    hold(7'h00, 2);
    chk("t4_bad", bad_count, 1);
    chk("t4_n", got_q.size(), 1);
    chk("t4_d0", q_at(0), 8);

    do_reset();
    digit_ready = 1'b0;
    hold(7'h06, 6); hold(7'h00, 6);
    hold(7'h5B, 6); hold(7'h00, 6);
    hold(7'h4F, 6); hold(7'h00, 6);
    hold(7'h66, 6); hold(7'h00, 6);
    chk("t5_full_noovf", overflow, 0);
    hold(7'h6D, 6); hold(7'h00, 6);
    chk("t5_ovf", overflow, 1);
    chk("t5_valid", digit_valid, 1);
    chk("t5_head", digit_data, 1);
    digit_ready = 1'b1;
    hold(7'h00, 6);
    chk("t5_n", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t5_d%0d", i), q_at(i), 32'(i + 1));
    chk("t5_drained", digit_valid, 0);
    chk("t5_hold", digit_data, 4);

    do_reset();
    digit_ready = 1'b0;
    hold(7'h06, 6); hold(7'h00, 6);
    hold(7'h5B, 6); hold(7'h00, 6);
    hold(7'h4F, 2);
    chk("t6_pre", digit_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_valid", digit_valid, 0);
    chk("t6_data", digit_data, 0);
    chk("t6_locked", locked, 0);
    chk("t6_ovf", overflow, 0);
    seg_in = pin(7'h00);
    tick();
    rst_n = 1'b1;
    got_q.delete();
    digit_ready = 1'b1;
    hold(7'h06, 6);
    hold(7'h00, 2);
    chk("t6_n", got_q.size(), 1);
    chk("t6_d0", q_at(0), 1);
    chk("t6_bad", bad_count, 0);

`ifdef SEG7_ACTIVE_LOW_EN
    do_reset();
    digit_ready = 1'b1;
    seg_in = 7'h40;
    repeat (6) tick();
    seg_in = 7'h7F;
    repeat (2) tick();
    chk("al_n", got_q.size(), 1);
    chk("al_d0", q_at(0), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
